dual_rail_issue: RTL and testbench
==================================

DUAL_RAIL_ISSUE -- requirements
Module: dual_rail_issue

Purpose: clocked issue stage directly upstream of the dual-rail adder. Accepts binary operands, drives them as dual-rail four-phase (data then spacer) codewords into the adder, detects completion, and returns the binary sum.

Encoding (pa_AsyncCordic::dual_rail_t): value 1 = {data_1=1,data_0=0}; value 0 = {0,1}; spacer = 2'b00; 2'b11 illegal.

Interface
REQ-001 SHALL have parameter SIZE, default pa_AsyncCordic::RW; datapath width is SIZE+1 bits, indices [SIZE:0].
REQ-002 SHALL have parameter TIMEOUT, default 64; maximum cycles spent in DRIVE or SPACER before an error is flagged.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 arst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  operand accept; a transfer occurs when in_valid && in_ready at a clk edge.
REQ-007 a_i, b_i  input  SIZE+1 each  binary operands.
REQ-008 sub_i  input  1  1 = subtract (carry-in rail data_1 drives b inversion in the adder).
REQ-009 add_a_o, add_b_o  output  dual_rail_t[SIZE:0]  dual-rail operands to the adder.
REQ-010 add_carry_o  output  dual_rail_t  carry-in to the adder.
REQ-011 add_sum_i  input  dual_rail_t[SIZE:0]  adder result; asynchronous to clk.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready at a clk edge.
REQ-014 sum_o  output  SIZE+1  binary sum.
REQ-015 err_o  output  1  transaction error; valid while out_valid=1.

Function
REQ-016 All outputs (add_*_o, in_ready, out_valid, sum_o, err_o) SHALL be registered.
REQ-017 add_sum_i SHALL pass through a 2-flop synchronizer per rail before any decision logic.
REQ-018 complete = every synchronized bit has exactly one rail high; empty = every synchronized bit is 2'b00; illegal = any bit 2'b11.
REQ-019 FSM states SHALL be IDLE, DRIVE, SPACER, HOLD.
REQ-020 IDLE: in_ready=1, adder outputs all spacer; on transfer, register operands, go DRIVE, in_ready=0 next cycle.
REQ-021 DRIVE: add_a_o/add_b_o encode registered a/b; add_carry_o = sub ? {1,0} : {0,1}; outputs appear the cycle after transfer.
REQ-022 DRIVE -> SPACER when complete is seen; sum_o SHALL capture the synchronized data_1 rails in that same cycle.
REQ-023 SPACER: all add_*_o = 2'b00; SPACER -> HOLD when empty is seen.
REQ-024 HOLD: out_valid=1, sum_o and err_o stable; on out_ready go IDLE, out_valid=0 next cycle.
REQ-025 in_ready SHALL be 0 in DRIVE, SPACER, HOLD; no operand is accepted until the previous result is consumed.
REQ-026 A cycle counter SHALL reset on every state entry; reaching TIMEOUT in DRIVE sets sticky err and forces SPACER (sum_o=0); reaching TIMEOUT in SPACER sets err and forces HOLD.
REQ-027 illegal seen in DRIVE or SPACER SHALL set sticky err for the transaction; state flow is otherwise unchanged.
REQ-028 err SHALL clear on entry to DRIVE.
REQ-029 Minimum transaction latency (transfer to out_valid) SHALL be 1 + (adder delay rounded up to cycles) + 2 sync + 1 capture, then the same for the spacer phase; with zero adder delay, out_valid rises 7 cycles after transfer.
REQ-030 Arithmetic SHALL be modulo 2^(SIZE+1); no overflow indication.

Reset
REQ-031 arst=1 at a clk edge SHALL force IDLE, all add_*_o=2'b00, in_ready=0 during reset then 1 the cycle after release, out_valid=0, sum_o=0, err_o=0, synchronizers and counter cleared.
REQ-032 arst mid-transaction SHALL abandon it without output; adder returns to spacer via REQ-031.

Verification (bench: SIZE=7, behavioural adder model with configurable delay)
REQ-033 a=8'h12, b=8'h34, sub=0, out_ready=1 -> sum_o=8'h46, err_o=0, adder sees data then all-spacer before out_valid.
REQ-034 a=8'h10, b=8'h01, sub=1 -> sum_o=8'h0F; a=8'hFF, b=8'h01, sub=0 -> sum_o=8'h00 (wrap).
REQ-035 Adder model stuck (never completes) -> out_valid after TIMEOUT+ cycles with err_o=1, sum_o=0; next transaction clean.
REQ-036 out_ready held 0 for 10 cycles in HOLD -> sum_o stable, in_ready=0 throughout, new in_valid ignored.
REQ-037 Model injects 2'b11 on bit 3 -> err_o=1 on that result.
REQ-038 arst asserted in DRIVE -> next cycle all adder inputs spacer, out_valid=0; following transaction correct.

Source files
------------

// File: rtl/dual_rail_issue_if.sv
// rtl/dual_rail_issue_if.sv - dual-rail codeword types and the issue-stage/adder channel
// The adder side is asynchronous; only add_sum_i is driven by the adder.
package pa_AsyncCordic;
  parameter int RW = 15;
  typedef struct packed {
    logic data_1;
    logic data_0;
  } dual_rail_t;
endpackage

interface dual_rail_issue_if #(
  parameter int SIZE = pa_AsyncCordic::RW
);
  import pa_AsyncCordic::*;

  dual_rail_t [SIZE:0] add_a_o;
  dual_rail_t [SIZE:0] add_b_o;
  dual_rail_t          add_carry_o;
  dual_rail_t [SIZE:0] add_sum_i;

  modport master (
    output add_a_o,
    output add_b_o,
    output add_carry_o,
    input  add_sum_i
  );

  modport slave (
    input  add_a_o,
    input  add_b_o,
    input  add_carry_o,
    output add_sum_i
  );
endinterface

// File: rtl/dual_rail_issue.sv
// rtl/dual_rail_issue.sv - clocked issue stage driving a four-phase dual-rail adder
// Data phase, then spacer phase, each closed by a synchronized completion/empty detect.
module dual_rail_issue
  import pa_AsyncCordic::*;
#(
  parameter int SIZE    = pa_AsyncCordic::RW,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIZE:0]      a_i,
  input  logic [SIZE:0]      b_i,
  input  logic               sub_i,
  dual_rail_issue_if.master  adder,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIZE:0]      sum_o,
  output logic               err_o
);

  typedef dual_rail_t [SIZE:0] rail_vec_t;
  typedef enum logic [1:0] {IDLE, DRIVE, SPACER, HOLD} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam dual_rail_t DR_ONE  = '{data_1: 1'b1, data_0: 1'b0};
  localparam dual_rail_t DR_ZERO = '{data_1: 1'b0, data_0: 1'b1};

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [SIZE:0]   sum_q;
  logic            err_q;
  rail_vec_t       add_a_q;
  rail_vec_t       add_b_q;
  dual_rail_t      add_c_q;
  rail_vec_t       sync1_q;
  rail_vec_t       sync2_q;

  logic            complete_d;
  logic            empty_d;
  logic            illegal_d;
  logic            timeout_d;
  logic [SIZE:0]   sum_d;

  function automatic rail_vec_t encode(input logic [SIZE:0] v);
    rail_vec_t r;
    for (int i = 0; i <= SIZE; i++) r[i] = v[i] ? DR_ONE : DR_ZERO;
    return r;
  endfunction

  // Decisions only ever look at the second synchronizer stage.
  always_comb begin
    complete_d = 1'b1;
    empty_d    = 1'b1;
    illegal_d  = 1'b0;
    sum_d      = '0;
    for (int i = 0; i <= SIZE; i++) begin
      if (sync2_q[i].data_1 == sync2_q[i].data_0) complete_d = 1'b0;
      if (sync2_q[i] != 2'b00) empty_d = 1'b0;
      if (sync2_q[i] == 2'b11) illegal_d = 1'b1;
      sum_d[i] = sync2_q[i].data_1;
    end
    timeout_d = (cnt_q == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_c_q     <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
    end else begin
      sync1_q <= adder.add_sum_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            add_a_q    <= encode(a_i);
            add_b_q    <= encode(b_i);
            add_c_q    <= sub_i ? DR_ONE : DR_ZERO;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            state_q    <= DRIVE;
          end
        end
        DRIVE: begin
          if (illegal_d) err_q <= 1'b1;
          if (complete_d || timeout_d) begin
            sum_q   <= complete_d ? sum_d : '0;
            if (!complete_d) err_q <= 1'b1;
            add_a_q <= '0;
            add_b_q <= '0;
            add_c_q <= '0;
            cnt_q   <= '0;
            state_q <= SPACER;
          end
        end
        SPACER: begin
          if (illegal_d) err_q <= 1'b1;
          if (empty_d || timeout_d) begin
            if (!empty_d) err_q <= 1'b1;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adder.add_a_o     = add_a_q;
  assign adder.add_b_o     = add_b_q;
  assign adder.add_carry_o = add_c_q;
  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign sum_o             = sum_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_dual_rail_issue.sv
// tb/tb_dual_rail_issue.sv - self-checking bench with a behavioural dual-rail adder model
// The adder model supports a cycle delay, a stuck (never completes) mode and an illegal-codeword mode.
module tb_dual_rail_issue;
  import pa_AsyncCordic::*;

  localparam int SIZE = 7;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       arst, in_valid, in_ready, sub_i, out_valid, out_ready, err_o;
  logic [7:0] a_i, b_i, sum_o;

  int pass_cnt = 0;
  int total    = 0;

  dual_rail_issue_if #(.SIZE(SIZE)) bus();

  dual_rail_issue #(.SIZE(SIZE), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .sub_i     (sub_i),
    .adder     (bus.master),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // Behavioural adder: decodes the data rails, adds or subtracts, re-encodes.
  int          delay    = 0;
  bit          stuck    = 1'b0;
  bit          ill      = 1'b0;
  int          data_cnt = 0;
  logic [15:0] a_v, b_v, target, model_out;
  logic [1:0]  c_v;
  logic [7:0]  ma, mb;
  logic [15:0] hist [0:7];

  function automatic logic [7:0] rail1(input logic [15:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[2*i+1];
    return r;
  endfunction

  function automatic logic [15:0] enc(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  assign a_v = bus.add_a_o;
  assign b_v = bus.add_b_o;
  assign c_v = bus.add_carry_o;

  always_comb begin
    target = '0;
    ma     = rail1(a_v);
    mb     = c_v[1] ? (~rail1(b_v) + 8'd1) : rail1(b_v);
    if (c_v != 2'b00) target = enc(ma + mb);
  end

  always @(posedge clk) begin
    hist[0] <= target;
    for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    data_cnt <= (c_v != 2'b00) ? data_cnt + 1 : 0;
  end

  always_comb begin
    model_out = (delay == 0) ? target : hist[delay-1];
    if (stuck) model_out = '0;
    if (ill && c_v != 2'b00 && data_cnt < 4) model_out[7:6] = 2'b11;
  end

  assign bus.add_sum_i = model_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // md: 0 normal, 1 stuck adder, 2 illegal codeword on bit 3
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input int d, input int md, input bit hold_test);
    logic [7:0] es;
    int         n;
    bit         saw_d, saw_s;
    delay = d;
    stuck = (md == 1);
    ill   = (md == 2);
    es    = (md == 1) ? 8'h00 : (s ? a - b : a + b);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a_i = a; b_i = b; sub_i = s; in_valid = 1'b1; out_ready = !hold_test;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1; saw_d = 0; saw_s = 0;
    while (!out_valid && n < 400) begin
      if (c_v != 2'b00) saw_d = 1;
      if (saw_d && a_v == 0 && b_v == 0 && c_v == 0) saw_s = 1;
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid", out_valid, 1);
    chk("sum", sum_o, es);
    chk("err", err_o, (md != 0));
    if (md == 0) chk("latency", n, 7 + 2 * d);
    if (md == 1) chk("timeout_latency", n > TO, 1);
    chk("saw_data", saw_d, 1);
    chk("saw_spacer", saw_s, 1);
    if (hold_test) begin
      in_valid = 1'b1; a_i = ~a;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        chk("hold_sum", sum_o, es);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_no_drive", c_v, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    arst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; sub_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_add_a", a_v, 0);
    chk("rst_add_c", c_v, 0);
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1);

    run(8'h12, 8'h34, 1'b0, 0, 0, 0);
    run(8'h10, 8'h01, 1'b1, 0, 0, 0);
    run(8'hFF, 8'h01, 1'b0, 2, 0, 0);
    run(8'h5A, 8'h33, 1'b0, 0, 1, 0);
    run(8'h21, 8'h42, 1'b0, 1, 0, 0);
    run(8'hA5, 8'h5A, 1'b1, 0, 0, 1);
    run(8'h07, 8'h09, 1'b0, 0, 2, 0);
    run(8'h07, 8'h09, 1'b0, 0, 0, 0);

    // reset while the adder is being driven
    delay = 3;
    @(negedge clk);
    a_i = 8'h77; b_i = 8'h11; sub_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drive_active", c_v != 2'b00, 1);
    arst = 1'b1;
    @(posedge clk); #1;
    chk("arst_add_a", a_v, 0);
    chk("arst_add_b", b_v, 0);
    chk("arst_add_c", c_v, 0);
    chk("arst_out_valid", out_valid, 0);
    arst = 1'b0;
    repeat (6) @(posedge clk);
    run(8'h77, 8'h11, 1'b0, 0, 0, 0);

    for (int r = 0; r < 8; r++)
      run(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
